// File: rtl/fir_pkg.sv
// Shared definitions for the multi-channel FIR: FSM state encoding,
// a constant clog2 helper and the accumulator width rule.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int fir_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Accumulator wide enough that summing every tap can never overflow.
    function automatic int fir_acc_w(input int in_w, input int coef_w, input int taps);
        return in_w + coef_w + fir_clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared multiply-accumulate unit: signed product, clearable accumulator,
// and the output scaling stage (arithmetic shift, then saturate when
// FIR_SAT_EN is defined, otherwise two's-complement wrap).
module fir_mac
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = 8,
    parameter int COEF_WIDTH   = 8,
    parameter int NUM_OF_TAPS  = 3,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OUT_SHIFT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acc_clr,
    input  logic                    acc_en,
    input  logic [INPUT_WIDTH-1:0]  sample,
    input  logic [COEF_WIDTH-1:0]   coef,
    output logic [OUTPUT_WIDTH-1:0] result
);

    localparam int PROD_W = INPUT_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = fir_acc_w(INPUT_WIDTH, COEF_WIDTH, NUM_OF_TAPS);

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc;

    assign product = $signed(sample) * $signed(coef);

    // Accumulator: clear on a new sample, add one product per MAC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + ACC_W'(product);
        end
    end

`ifdef FIR_SAT_EN
    localparam int WIDE_W = (ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH;
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUTPUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    logic signed [WIDE_W-1:0] shifted;

    // Scale the accumulator and clamp it into the signed output range.
    always_comb begin
        shifted = WIDE_W'(acc >>> OUT_SHIFT);
        if (shifted > WIDE_W'(OUT_MAX)) begin
            result = OUT_MAX;
        end else if (shifted < WIDE_W'(OUT_MIN)) begin
            result = OUT_MIN;
        end else begin
            result = shifted[OUTPUT_WIDTH-1:0];
        end
    end
`else
    // Scale the accumulator and keep its low bits (two's-complement wrap).
    always_comb begin
        result = OUTPUT_WIDTH'(acc >>> OUT_SHIFT);
    end
`endif

endmodule

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel FIR. Holds the control FSM, the per-channel
// delay lines, the shared coefficient bank and the sticky drop flag; the
// arithmetic lives in fir_mac. Optional macro: FIR_SAT_EN selects output
// saturation instead of wrap.
//
// Handshake: a sample transfers on a rising edge where input_data_flag and
// input_ready are both high and input_channel < NUM_CH. The source is never
// stalled: a flag while input_ready is low, or with an out-of-range channel,
// discards the sample and sets input_drop. output_data_flag is a one-cycle
// strobe with no back-pressure.
module fir_mc
    import fir_pkg::*;
#(
    parameter int NUM_OF_TAPS  = 3,
    parameter int INPUT_WIDTH  = 8,
    parameter int COEF_WIDTH   = 8,
    parameter int NUM_CH       = 2,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OUT_SHIFT    = 0,
    localparam int CH_W        = (NUM_CH > 1) ? fir_clog2(NUM_CH) : 1,
    localparam int TAP_W       = fir_clog2(NUM_OF_TAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUT_WIDTH-1:0]  input_data,
    input  logic                    input_data_flag,
    input  logic [CH_W-1:0]         input_channel,
    output logic                    input_ready,
    output logic                    input_drop,
    input  logic                    drop_clr,
    input  logic                    coef_wr_en,
    input  logic [TAP_W-1:0]        coef_addr,
    input  logic [COEF_WIDTH-1:0]   coef_data,
    output logic [OUTPUT_WIDTH-1:0] output_data,
    output logic                    output_data_flag,
    output logic [CH_W-1:0]         output_channel
);

    localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_OF_TAPS - 1);

    fir_state_t             state;
    logic [TAP_W-1:0]       tap_idx;
    logic [CH_W-1:0]        cur_ch;
    logic [INPUT_WIDTH-1:0] dline [NUM_CH][NUM_OF_TAPS];
    logic [COEF_WIDTH-1:0]  coef_bank [NUM_OF_TAPS];

    logic                    ch_ok;
    logic                    accept;
    logic                    drop_set;
    logic [INPUT_WIDTH-1:0]  mac_sample;
    logic [COEF_WIDTH-1:0]   mac_coef;
    logic [OUTPUT_WIDTH-1:0] mac_result;

    assign ch_ok    = ({1'b0, input_channel} < NUM_CH_V);
    assign accept   = (state == ST_IDLE) && input_data_flag && ch_ok;
    assign drop_set = input_data_flag && !accept;

    // Operand select: the current channel's sample and coefficient at tap_idx.
    always_comb begin
        mac_sample = '0;
        mac_coef   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < NUM_OF_TAPS; k++) begin
                if (cur_ch == CH_W'(c) && tap_idx == TAP_W'(k)) begin
                    mac_sample = dline[c][k];
                end
            end
        end
        for (int k = 0; k < NUM_OF_TAPS; k++) begin
            if (tap_idx == TAP_W'(k)) begin
                mac_coef = coef_bank[k];
            end
        end
    end

    fir_mac #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .COEF_WIDTH   (COEF_WIDTH),
        .NUM_OF_TAPS  (NUM_OF_TAPS),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .OUT_SHIFT    (OUT_SHIFT)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_clr (accept),
        .acc_en  (state == ST_MAC),
        .sample  (mac_sample),
        .coef    (mac_coef),
        .result  (mac_result)
    );

    // Delay lines: an accepted sample shifts into its own channel only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < NUM_OF_TAPS; k++) begin
                    dline[c][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (input_channel == CH_W'(c)) begin
                    dline[c][0] <= input_data;
                    for (int k = 1; k < NUM_OF_TAPS; k++) begin
                        dline[c][k] <= dline[c][k-1];
                    end
                end
            end
        end
    end

    // Coefficient bank: resets to identity; out-of-range addresses match no tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OF_TAPS; k++) begin
                coef_bank[k] <= (k == 0) ? COEF_WIDTH'(1) : '0;
            end
        end else if (coef_wr_en) begin
            for (int k = 0; k < NUM_OF_TAPS; k++) begin
                if (coef_addr == TAP_W'(k)) begin
                    coef_bank[k] <= coef_data;
                end
            end
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_drop <= 1'b0;
        end else if (drop_set) begin
            input_drop <= 1'b1;
        end else if (drop_clr) begin
            input_drop <= 1'b0;
        end
    end

    // Control FSM: accept in IDLE, one tap per MAC cycle, publish in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            tap_idx          <= '0;
            cur_ch           <= '0;
            input_ready      <= 1'b1;
            output_data      <= '0;
            output_data_flag <= 1'b0;
            output_channel   <= '0;
        end else begin
            output_data_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_ch      <= input_channel;
                        tap_idx     <= '0;
                        input_ready <= 1'b0;
                        state       <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (tap_idx == LAST_TAP) begin
                        state <= ST_OUT;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    output_data      <= mac_result;
                    output_channel   <= cur_ch;
                    output_data_flag <= 1'b1;
                    input_ready      <= 1'b1;
                    state            <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mc.sv
// Testbench for fir_mc, three channels so an out-of-range channel (3) exists.
// A reference model keeps each channel's sample history and the coefficient
// bank as plain integers and predicts every output.
module tb_fir_mc;

    localparam int TAPS      = 3;
    localparam int OUT_SHIFT = 0;
    localparam int NCH       = 3;
    localparam int LATENCY   = TAPS + 1;
`ifdef FIR_SAT_EN
    localparam logic [15:0] SAT_THIRD = 16'h8000;
`else
    localparam logic [15:0] SAT_THIRD = 16'h4180;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  input_data;
    logic        input_data_flag;
    logic [1:0]  input_channel;
    logic        input_ready;
    logic        input_drop;
    logic        drop_clr;
    logic        coef_wr_en;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic [15:0] output_data;
    logic        output_data_flag;
    logic [1:0]  output_channel;

    int checks = 0;
    int errors = 0;

    // scoreboard
    logic [15:0] exp_q[$];
    logic [1:0]  exp_ch_q[$];

    // reference model state
    int coef_m[TAPS];
    int hist_m[NCH][TAPS];

    fir_mc #(
        .NUM_OF_TAPS  (TAPS),
        .INPUT_WIDTH  (8),
        .COEF_WIDTH   (8),
        .NUM_CH       (NCH),
        .OUTPUT_WIDTH (16),
        .OUT_SHIFT    (OUT_SHIFT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_data       (input_data),
        .input_data_flag  (input_data_flag),
        .input_channel    (input_channel),
        .input_ready      (input_ready),
        .input_drop       (input_drop),
        .drop_clr         (drop_clr),
        .coef_wr_en       (coef_wr_en),
        .coef_addr        (coef_addr),
        .coef_data        (coef_data),
        .output_data      (output_data),
        .output_data_flag (output_data_flag),
        .output_channel   (output_channel)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            coef_m[k] = (k == 0) ? 1 : 0;
            for (int c = 0; c < NCH; c++) hist_m[c][k] = 0;
        end
        exp_q.delete();
        exp_ch_q.delete();
    endfunction

    function automatic void model_coef(input int addr, input int val);
        if (addr < TAPS) coef_m[addr] = val;
    endfunction

    function automatic void model_sample(input int ch, input int x);
        longint y;
        logic [15:0] r;
        for (int k = TAPS - 1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
        hist_m[ch][0] = x;
        y = 0;
        for (int k = 0; k < TAPS; k++) y += longint'(coef_m[k]) * longint'(hist_m[ch][k]);
        y = y >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
`endif
        r = y[15:0];
        exp_q.push_back(r);
        exp_ch_q.push_back(2'(ch));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_data  = d;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        model_coef(int'(a), int'($signed(d)));
    endtask

    // Presents one sample for one edge; returns 1 ns after that edge.
    task automatic start_sample(input logic [1:0] ch, input logic [7:0] d);
        @(negedge clk);
        input_data_flag = 1'b1;
        input_channel   = ch;
        input_data      = d;
        @(posedge clk);
        #1;
        input_data_flag = 1'b0;
    endtask

    task automatic pulse_drop_clr();
        @(negedge clk);
        drop_clr = 1'b1;
        @(posedge clk);
        #1;
        drop_clr = 1'b0;
    endtask

    // Watches up to max_cyc edges for the output strobe.
    task automatic wait_output(input int max_cyc, output bit seen, output int lat,
                               output logic [15:0] d, output logic [1:0] c);
        seen = 1'b0;
        lat  = 0;
        d    = '0;
        c    = '0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            #1;
            if (output_data_flag === 1'b1) begin
                seen = 1'b1;
                lat  = n;
                d    = output_data;
                c    = output_channel;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if (input_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", input_ready); end
        checks++;
        if (input_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", input_drop); end
        checks++;
        if (output_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", output_data); end
        checks++;
        if (output_data_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", output_data_flag); end
        checks++;
        if (output_channel !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d want 0", output_channel); end
    endtask

    task automatic test_identity();
        bit seen; int lat; logic [15:0] d; logic [1:0] c;
        start_sample(2'd0, 8'h12);
        model_sample(0, 18);
        checks++;
        if (input_ready !== 1'b0) begin errors++; $display("FAIL ident_busy ready got %b want 0", input_ready); end
        wait_output(20, seen, lat, d, c);
        checks++;
        if (!seen || d !== exp_q.pop_front() || c !== exp_ch_q.pop_front())
            begin errors++; $display("FAIL ident_out seen %0b data %h ch %0d want 0012 ch 0", seen, d, c); end
        checks++;
        if (lat !== LATENCY) begin errors++; $display("FAIL ident_latency got %0d want %0d", lat, LATENCY); end
        checks++;
        if (input_ready !== 1'b1) begin errors++; $display("FAIL ident_ready_back got %b want 1", input_ready); end
    endtask

    task automatic test_programmed_taps();
        bit seen; int lat; logic [15:0] d; logic [1:0] c; logic [15:0] e;
        logic [7:0] xs [3] = '{8'd10, 8'd20, 8'd30};
        logic [15:0] lit [3] = '{16'd10, 16'd40, 16'd80};
        apply_reset();
        write_coef(2'd0, 8'd1);
        write_coef(2'd1, 8'd2);
        write_coef(2'd2, 8'd1);
        for (int i = 0; i < 3; i++) begin
            start_sample(2'd0, xs[i]);
            model_sample(0, int'(xs[i]));
            wait_output(20, seen, lat, d, c);
            e = exp_q.pop_front();
            void'(exp_ch_q.pop_front());
            checks++;
            if (!seen || d !== e || d !== lit[i] || c !== 2'd0)
                begin errors++; $display("FAIL taps_out%0d seen %0b data %0d ch %0d want %0d ch 0", i, seen, d, c, e); end
        end
    endtask

    task automatic test_channel_independence();
        bit seen; int lat; logic [15:0] d; logic [1:0] c; logic [15:0] e; logic [1:0] ec;
        logic [1:0] chs [3] = '{2'd0, 2'd1, 2'd0};
        logic [7:0] xs [3] = '{8'd10, 8'd100, 8'd20};
        apply_reset();
        write_coef(2'd1, 8'd2);
        write_coef(2'd2, 8'd1);
        for (int i = 0; i < 3; i++) begin
            start_sample(chs[i], xs[i]);
            model_sample(int'(chs[i]), int'(xs[i]));
            wait_output(20, seen, lat, d, c);
            e  = exp_q.pop_front();
            ec = exp_ch_q.pop_front();
            checks++;
            if (!seen || d !== e || c !== ec)
                begin errors++; $display("FAIL chan_out%0d seen %0b data %0d ch %0d want %0d ch %0d", i, seen, d, c, e, ec); end
        end
    endtask

    task automatic test_saturation();
        bit seen; int lat; logic [15:0] d; logic [1:0] c; logic [15:0] e;
        apply_reset();
        for (int k = 0; k < TAPS; k++) write_coef(2'(k), 8'd127);
        for (int i = 0; i < 3; i++) begin
            start_sample(2'd0, 8'h80);
            model_sample(0, -128);
            wait_output(20, seen, lat, d, c);
            e = exp_q.pop_front();
            void'(exp_ch_q.pop_front());
            checks++;
            if (!seen || d !== e)
                begin errors++; $display("FAIL sat_out%0d seen %0b data %h want %h", i, seen, d, e); end
        end
        checks++;
        if (d !== SAT_THIRD) begin errors++; $display("FAIL sat_third got %h want %h", d, SAT_THIRD); end
    endtask

    task automatic test_coef_timing();
        bit seen; int lat; logic [15:0] d; logic [1:0] c; logic [15:0] e;
        apply_reset();
        write_coef(2'd1, 8'd2);
        write_coef(2'd2, 8'd1);
        // write tap 0 while tap 0 is being read: old value applies
        start_sample(2'd0, 8'd10);
        model_sample(0, 10);
        coef_wr_en = 1'b1; coef_addr = 2'd0; coef_data = 8'd5;
        @(posedge clk); #1;
        coef_wr_en = 1'b0;
        model_coef(0, 5);
        wait_output(20, seen, lat, d, c);
        e = exp_q.pop_front(); void'(exp_ch_q.pop_front());
        checks++;
        if (!seen || d !== e) begin errors++; $display("FAIL coef_same_tap seen %0b data %0d want %0d", seen, d, e); end
        // write tap 1 while tap 0 is being read: new value applies
        start_sample(2'd0, 8'd20);
        coef_wr_en = 1'b1; coef_addr = 2'd1; coef_data = 8'd3;
        @(posedge clk); #1;
        coef_wr_en = 1'b0;
        model_coef(1, 3);
        model_sample(0, 20);
        wait_output(20, seen, lat, d, c);
        e = exp_q.pop_front(); void'(exp_ch_q.pop_front());
        checks++;
        if (!seen || d !== e) begin errors++; $display("FAIL coef_later_tap seen %0b data %0d want %0d", seen, d, e); end
        // address beyond the last tap is ignored
        write_coef(2'd3, 8'd99);
        start_sample(2'd0, 8'd1);
        model_sample(0, 1);
        wait_output(20, seen, lat, d, c);
        e = exp_q.pop_front(); void'(exp_ch_q.pop_front());
        checks++;
        if (!seen || d !== e) begin errors++; $display("FAIL coef_oob_ignored seen %0b data %0d want %0d", seen, d, e); end
    endtask

    task automatic test_drop();
        bit seen; int lat; logic [15:0] d; logic [1:0] c; logic [15:0] e; logic [1:0] ec;
        pulse_drop_clr();
        start_sample(2'd1, 8'd7);
        model_sample(1, 7);
        // second sample one cycle after acceptance
        input_data_flag = 1'b1; input_channel = 2'd0; input_data = 8'd55;
        @(posedge clk); #1;
        input_data_flag = 1'b0;
        wait_output(20, seen, lat, d, c);
        e = exp_q.pop_front(); ec = exp_ch_q.pop_front();
        checks++;
        if (!seen || d !== e || c !== ec)
            begin errors++; $display("FAIL drop_first_out seen %0b data %0d ch %0d want %0d ch %0d", seen, d, c, e, ec); end
        wait_output(10, seen, lat, d, c);
        checks++;
        if (seen) begin errors++; $display("FAIL drop_extra_out got strobe data %0d want none", d); end
        checks++;
        if (input_drop !== 1'b1) begin errors++; $display("FAIL drop_busy_flag got %b want 1", input_drop); end
        pulse_drop_clr();
        checks++;
        if (input_drop !== 1'b0) begin errors++; $display("FAIL drop_clear got %b want 0", input_drop); end
        // out-of-range channel
        start_sample(2'd3, 8'd9);
        checks++;
        if (input_drop !== 1'b1 || input_ready !== 1'b1)
            begin errors++; $display("FAIL drop_bad_ch drop %b ready %b want 1 1", input_drop, input_ready); end
        wait_output(10, seen, lat, d, c);
        checks++;
        if (seen) begin errors++; $display("FAIL drop_bad_ch_out got strobe want none"); end
        // clear and new drop in the same cycle: set wins
        pulse_drop_clr();
        start_sample(2'd0, 8'd3);
        model_sample(0, 3);
        input_data_flag = 1'b1; drop_clr = 1'b1;
        @(posedge clk); #1;
        input_data_flag = 1'b0; drop_clr = 1'b0;
        checks++;
        if (input_drop !== 1'b1) begin errors++; $display("FAIL drop_set_wins got %b want 1", input_drop); end
        wait_output(20, seen, lat, d, c);
        e = exp_q.pop_front(); void'(exp_ch_q.pop_front());
        checks++;
        if (!seen || d !== e)
            begin errors++; $display("FAIL drop_delay_unchanged seen %0b data %0d want %0d", seen, d, e); end
    endtask

    task automatic test_reset_mid_mac();
        bit seen; int lat; logic [15:0] d; logic [1:0] c; logic [15:0] e;
        start_sample(2'd0, 8'd7);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (input_ready !== 1'b1 || output_data_flag !== 1'b0)
            begin errors++; $display("FAIL rst_mid_state ready %b flag %b want 1 0", input_ready, output_data_flag); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_output(10, seen, lat, d, c);
        checks++;
        if (seen) begin errors++; $display("FAIL rst_mid_no_strobe got strobe data %0d want none", d); end
        write_coef(2'd1, 8'd1);
        write_coef(2'd2, 8'd1);
        start_sample(2'd0, 8'd5);
        model_sample(0, 5);
        wait_output(20, seen, lat, d, c);
        e = exp_q.pop_front(); void'(exp_ch_q.pop_front());
        checks++;
        if (!seen || d !== e || d !== 16'd5)
            begin errors++; $display("FAIL rst_mid_cleared seen %0b data %0d want %0d", seen, d, e); end
    endtask

    task automatic test_random();
        bit seen; int lat; logic [15:0] d; logic [1:0] c; logic [15:0] e; logic [1:0] ec;
        logic [7:0] rd; logic [1:0] rc; int op;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 9));
            rd = 8'($urandom_range(0, 255));
            if (op < 2) begin
                write_coef(2'($urandom_range(0, 3)), rd);
            end else if (op < 9) begin
                rc = 2'($urandom_range(0, NCH - 1));
                start_sample(rc, rd);
                model_sample(int'(rc), int'($signed(rd)));
                wait_output(20, seen, lat, d, c);
                e  = exp_q.pop_front();
                ec = exp_ch_q.pop_front();
                checks++;
                if (!seen || d !== e || c !== ec || lat != LATENCY)
                    begin errors++; $display("FAIL rand_out%0d seen %0b data %h ch %0d lat %0d want %h ch %0d lat %0d", i, seen, d, c, lat, e, ec, LATENCY); end
            end else begin
                pulse_drop_clr();
                start_sample(2'd3, rd);
                wait_output(8, seen, lat, d, c);
                checks++;
                if (seen || input_drop !== 1'b1)
                    begin errors++; $display("FAIL rand_bad_ch%0d strobe %0b drop %b want 0 1", i, seen, input_drop); end
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n           = 1'b0;
        input_data      = '0;
        input_data_flag = 1'b0;
        input_channel   = '0;
        drop_clr        = 1'b0;
        coef_wr_en      = 1'b0;
        coef_addr       = '0;
        coef_data       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_identity();
        test_programmed_taps();
        test_channel_independence();
        test_saturation();
        test_coef_timing();
        test_drop();
        test_reset_mid_mac();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
